traffic_phase_scheduler: RTL

//  Timed phase sequencer for a two-road intersection (main/side) with a pedestrian walk phase.

---
 rtl/traffic_phase_scheduler.sv | 111 +++++++++++
 1 files changed

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - timed main/side/walk phase sequencer with all-red clearance
// Dwell counts advance on tick; lights are registered from the next-state decode.
module traffic_phase_scheduler #(
   parameter int CNT_W     = 8,
   parameter int GREEN_MIN = 10,
   parameter int GREEN_MAX = 30,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int WALK_T    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       en,
   input  logic       side_req,
   input  logic       ped_req,
   output logic [2:0] main_light,
   output logic [2:0] side_light,
   output logic       walk,
   output logic [2:0] phase,
   output logic       ped_pending
);

   typedef enum logic [2:0] {
      S_ALLRED_A = 3'd0,
      S_MAIN_G   = 3'd1,
      S_MAIN_Y   = 3'd2,
      S_ALLRED_B = 3'd3,
      S_SIDE_G   = 3'd4,
      S_SIDE_Y   = 3'd5,
      S_WALK     = 3'd6,
      S_HOLD     = 3'd7
   } state_t;

   localparam logic [CNT_W-1:0] L_GMIN   = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] L_GMAX   = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] L_WALK   = CNT_W'(WALK_T - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   state_t           w_next;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_ped_next;
   logic             w_green_min;

   assign w_green_min = tick && (r_cnt >= L_GMIN);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_ALLRED_A:
            if (tick && r_cnt == L_ALLRED)
               w_next = !en ? S_HOLD : (r_ped_pending_or_walk() ? S_WALK : S_MAIN_G);
         S_MAIN_G:
            if (w_green_min && (side_req || ped_pending || !en))
               w_next = S_MAIN_Y;
         S_MAIN_Y:
            if (tick && r_cnt == L_YELLOW) w_next = S_ALLRED_B;
         S_ALLRED_B:
            if (tick && r_cnt == L_ALLRED)
               w_next = !en ? S_HOLD : side_req ? S_SIDE_G : ped_pending ? S_WALK : S_MAIN_G;
         S_SIDE_G:
            if ((w_green_min && (!side_req || !en)) || (tick && r_cnt == L_GMAX))
               w_next = S_SIDE_Y;
         S_SIDE_Y:
            if (tick && r_cnt == L_YELLOW) w_next = S_ALLRED_A;
         S_WALK:
            if (tick && r_cnt == L_WALK) w_next = S_MAIN_G;
         S_HOLD:
            if (en) w_next = S_ALLRED_A;
         default: w_next = S_ALLRED_A;
      endcase
   end

   function automatic logic r_ped_pending_or_walk();
      return ped_pending;
   endfunction

   // Counter saturates so an unbounded main green can never wrap back below GREEN_MIN.
   always_comb begin
      w_cnt_next = r_cnt;
      if (w_next != r_state)
         w_cnt_next = '0;
      else if (tick && r_cnt != '1)
         w_cnt_next = r_cnt + 1'b1;
   end

   assign w_ped_next = ped_req || (ped_pending && !(w_next == S_WALK && r_state != S_WALK));
   assign phase      = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_ALLRED_A;
         r_cnt       <= '0;
         ped_pending <= 1'b0;
         main_light  <= 3'b001;
         side_light  <= 3'b001;
         walk        <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt_next;
         ped_pending <= w_ped_next;
         main_light  <= (w_next == S_MAIN_G) ? 3'b100 : (w_next == S_MAIN_Y) ? 3'b010 : 3'b001;
         side_light  <= (w_next == S_SIDE_G) ? 3'b100 : (w_next == S_SIDE_Y) ? 3'b010 : 3'b001;
         walk        <= (w_next == S_WALK);
      end
   end

endmodule
